// File: rtl/stopwatch_counter_pkg.sv
// ============================================================================
// stopwatch_counter_pkg : shared widths, wrap limits, blank-mask bit layout
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package stopwatch_counter_pkg;

  localparam int BCD_W       = 4;
  localparam int SEC_MAX_DEF = 59;
  localparam int MIN_MAX_DEF = 59;

  // Bit positions inside blank_mask, shared with the display multiplexer
  localparam int BLANK_MIN_TENS = 3;
  localparam int BLANK_MIN_ONES = 2;
  localparam int BLANK_SEC_TENS = 1;
  localparam int BLANK_SEC_ONES = 0;

  typedef enum logic {
    RUN_PAUSED = 1'b0,
    RUN_ACTIVE = 1'b1
  } run_state_e;

  // Blank the pair of digits belonging to the field being adjusted
  function automatic logic [3:0] blank_mask_for(input logic sel, input logic phase);
    logic [3:0] m;
    m = 4'b0000;
    if (sel) begin
      m[BLANK_SEC_TENS] = phase;
      m[BLANK_SEC_ONES] = phase;
    end else begin
      m[BLANK_MIN_TENS] = phase;
      m[BLANK_MIN_ONES] = phase;
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stopwatch_counter_bcd_mod60_counter.sv
// ============================================================================
// bcd_mod60_counter : two-digit BCD counter wrapping at MAX, carry out on wrap
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_mod60_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             carry
);

  localparam logic [BCD_W-1:0] TENS_MAX = BCD_W'(MAX / 10);
  localparam logic [BCD_W-1:0] ONES_MAX = BCD_W'(MAX % 10);

  logic [BCD_W-1:0] tens_q, tens_d;
  logic [BCD_W-1:0] ones_q, ones_d;
  logic             at_max;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    at_max = (tens_q == TENS_MAX) && (ones_q == ONES_MAX);
    if (clr) begin
      tens_d = '0;
      ones_d = '0;
    end else if (inc) begin
      if (at_max) begin
        tens_d = '0;
        ones_d = '0;
      end else if (ones_q == BCD_W'(9)) begin
        tens_d = tens_q + BCD_W'(1);
        ones_d = '0;
      end else begin
        ones_d = ones_q + BCD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens  = tens_q;
  assign ones  = ones_q;
  // A clear wins over the wrap, so no carry escapes into the next field
  assign carry = inc && at_max && !clr;

endmodule

`default_nettype wire

// File: rtl/stopwatch_counter.sv
// ============================================================================
// stopwatch_counter : MM:SS BCD stopwatch with pause, clear and manual adjust
// Optional blink of the adjusted field: define STOPWATCH_BLINK_EN
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int SEC_MAX = SEC_MAX_DEF,
  parameter int MIN_MAX = MIN_MAX_DEF
) (
  input  logic             clk_100mhz,
  input  logic             rst_n,
  input  logic             tick_1hz,
  input  logic             tick_2hz,
  input  logic             tick_4hz,
  input  logic             pause_btn,
  input  logic             clear_btn,
  input  logic             adj,
  input  logic             sel,
  output logic [BCD_W-1:0] min_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             running,
  output logic [3:0]       blank_mask
);

  run_state_e run_q, run_d;
  logic       sec_inc;
  logic       min_inc;
  logic       sec_carry;
  logic       min_carry_unused;

  always_comb begin
    run_d = run_q;
    if (pause_btn) begin
      run_d = (run_q == RUN_ACTIVE) ? RUN_PAUSED : RUN_ACTIVE;
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= RUN_PAUSED;
    end else begin
      run_q <= run_d;
    end
  end

  assign running = (run_q == RUN_ACTIVE);

  // Tick qualification uses the pre-toggle run state; adjust never carries
  always_comb begin
    sec_inc = 1'b0;
    min_inc = 1'b0;
    if (adj) begin
      sec_inc = tick_2hz && sel;
      min_inc = tick_2hz && !sel;
    end else begin
      sec_inc = running && tick_1hz;
      min_inc = sec_carry;
    end
  end

  bcd_mod60_counter #(.MAX(SEC_MAX)) u_sec (
    .clk   (clk_100mhz),
    .rst_n (rst_n),
    .clr   (clear_btn),
    .inc   (sec_inc),
    .tens  (sec_tens),
    .ones  (sec_ones),
    .carry (sec_carry)
  );

  bcd_mod60_counter #(.MAX(MIN_MAX)) u_min (
    .clk   (clk_100mhz),
    .rst_n (rst_n),
    .clr   (clear_btn),
    .inc   (min_inc),
    .tens  (min_tens),
    .ones  (min_ones),
    .carry (min_carry_unused)
  );

`ifdef STOPWATCH_BLINK_EN
  logic       phase_q, phase_d;
  logic [3:0] blank_mask_q, blank_mask_d;

  always_comb begin
    phase_d      = 1'b0;
    blank_mask_d = 4'b0000;
    if (adj) begin
      phase_d      = phase_q ^ tick_4hz;
      blank_mask_d = blank_mask_for(sel, phase_d);
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= 1'b0;
      blank_mask_q <= 4'b0000;
    end else begin
      phase_q      <= phase_d;
      blank_mask_q <= blank_mask_d;
    end
  end

  assign blank_mask = blank_mask_q;
`else
  logic unused_tick_4hz;
  assign unused_tick_4hz = tick_4hz;
  assign blank_mask      = 4'b0000;
`endif

endmodule

`default_nettype wire
